// File: rtl/sprite_line_fetcher.sv
// Sprite line fetcher: during horizontal blanking, copies the sprite row needed
// for the next scanline from a synchronous ROM into a line buffer. During active
// video it streams that row to the colour stage, aligned to hcount with one
// cycle of latency. The timing generator must delay bright/hcount by one cycle
// on the colour-stage side to match that latency.
module sprite_line_fetcher #(
    parameter int DATA_WIDTH = 24,
    parameter int SPRITE_W   = 32,
    parameter int SPRITE_H   = 32,
    parameter int ADDR_WIDTH = 10,
    parameter int H_ACTIVE   = 640,
    parameter int V_ACTIVE   = 480,
    parameter int V_TOTAL    = 525
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic [9:0]            i_hcount,
    input  logic [9:0]            i_vcount,
    input  logic                  i_bright,
    input  logic [9:0]            i_sprite_x,
    input  logic [9:0]            i_sprite_y,
    input  logic                  i_sprite_visible,
    output logic [ADDR_WIDTH-1:0] o_rom_addr,
    output logic                  o_rom_rd,
    input  logic [DATA_WIDTH-1:0] i_rom_data,
    output logic [DATA_WIDTH-1:0] o_pixel,
    output logic                  o_pix_en,
    output logic                  o_busy
);

    localparam int COL_W = (SPRITE_W > 1) ? $clog2(SPRITE_W) : 1;
    localparam int ROW_W = (SPRITE_H > 1) ? $clog2(SPRITE_H) : 1;

    // All screen-coordinate arithmetic is done in 11 bits so sums never wrap.
    localparam logic [10:0]      C_H_ACTIVE = 11'(H_ACTIVE);
    localparam logic [10:0]      C_V_ACTIVE = 11'(V_ACTIVE);
    localparam logic [10:0]      C_V_LAST   = 11'(V_TOTAL - 1);
    localparam logic [10:0]      C_SPR_W    = 11'(SPRITE_W);
    localparam logic [10:0]      C_SPR_H    = 11'(SPRITE_H);
    localparam logic [COL_W-1:0] C_COL_LAST = COL_W'(SPRITE_W - 1);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        DRAIN,
        READY
    } state_t;

    state_t                r_state;
    state_t                w_nextState;
    logic [COL_W-1:0]      r_col;
    logic [COL_W-1:0]      r_colD;
    logic                  r_rdD;
    logic [ROW_W-1:0]      r_row;
    logic [9:0]            r_latchedX;
    logic                  r_rowValid;
    logic [DATA_WIDTH-1:0] r_lineBuf [SPRITE_W];

    logic                  w_lineStart;
    logic [10:0]           w_nextLine;
    logic [10:0]           w_spriteY;
    logic                  w_hit;
    logic [ROW_W-1:0]      w_row;
    logic [10:0]           w_h;
    logic [10:0]           w_x;
    logic                  w_inSpan;
    logic [COL_W-1:0]      w_bufIdx;

    // Line-start detection and hit evaluation for the upcoming scanline.
    always_comb begin
        w_lineStart = ({1'b0, i_hcount} == C_H_ACTIVE);
        w_nextLine  = ({1'b0, i_vcount} == C_V_LAST) ? 11'd0 : ({1'b0, i_vcount} + 11'd1);
        w_spriteY   = {1'b0, i_sprite_y};
        w_hit       = i_sprite_visible
                      && (w_nextLine <  C_V_ACTIVE)
                      && (w_nextLine >= w_spriteY)
                      && (w_nextLine <  (w_spriteY + C_SPR_H));
        w_row       = ROW_W'(w_nextLine - w_spriteY);
    end

    // Next-state and fetch-side outputs; a line start overrides any state, which
    // also aborts a fetch that is still running.
    always_comb begin
        w_nextState = r_state;
        o_rom_rd    = 1'b0;
        o_busy      = 1'b0;
        o_rom_addr  = '0;
        case (r_state)
            FETCH: begin
                o_rom_rd   = 1'b1;
                o_busy     = 1'b1;
                o_rom_addr = (ADDR_WIDTH'(r_row) << COL_W) | ADDR_WIDTH'(r_col);
                if (r_col == C_COL_LAST) begin
                    w_nextState = DRAIN;
                end
            end
            DRAIN: begin
                o_busy      = 1'b1;
                w_nextState = READY;
            end
            default: begin
                w_nextState = r_state;
            end
        endcase
        if (w_lineStart) begin
            w_nextState = w_hit ? FETCH : IDLE;
        end
    end

    // State register plus fetch bookkeeping: column counter, row, latched x and
    // row-valid flag (only set once the drain cycle has captured the last word).
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= IDLE;
            r_col      <= '0;
            r_row      <= '0;
            r_latchedX <= '0;
            r_rowValid <= 1'b0;
        end else begin
            r_state <= w_nextState;
            if (w_lineStart) begin
                r_latchedX <= i_sprite_x;
                r_rowValid <= 1'b0;
                r_col      <= '0;
                if (w_hit) begin
                    r_row <= w_row;
                end
            end else begin
                if (r_state == FETCH) begin
                    r_col <= r_col + 1'b1;
                end
                if (r_state == DRAIN) begin
                    r_rowValid <= 1'b1;
                end
            end
        end
    end

    // Delay the read strobe and column by one cycle to match ROM latency.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rdD  <= 1'b0;
            r_colD <= '0;
        end else begin
            r_rdD  <= o_rom_rd;
            r_colD <= r_col;
        end
    end

    // Line buffer write-back of the returned ROM word; contents need no reset.
    always_ff @(posedge i_clk) begin
        if (r_rdD) begin
            r_lineBuf[r_colD] <= i_rom_data;
        end
    end

    // Horizontal span test against the x position latched at line start.
    always_comb begin
        w_h      = {1'b0, i_hcount};
        w_x      = {1'b0, r_latchedX};
        w_inSpan = r_rowValid && i_bright && (w_h >= w_x) && (w_h < (w_x + C_SPR_W));
        w_bufIdx = COL_W'(w_h - w_x);
    end

    // Registered pixel output, one cycle behind hcount/bright.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_pix_en <= 1'b0;
            o_pixel  <= '0;
        end else begin
            o_pix_en <= w_inSpan;
            o_pixel  <= w_inSpan ? r_lineBuf[w_bufIdx] : '0;
        end
    end

endmodule
